mux4_rr_arbiter: RTL and testbench
==================================

// Module: mux4_rr_arbiter
// PURPOSE
// - Round-robin controller sharing the 4:1 structural mux output path among four requesters.
// - Owns the mux selects: s1 picks within a pair (a/b, c/d); s2 picks the pair.
// - Presents the shared output to one downstream consumer via valid/ready.
// - Sits directly beside multiplexer4to1_structural; its s1/s2 drive that mux.
// PARAMETERS
// - MAX_HOLD  4  max beats transferred per grant before forced re-arbitration (>=1)
// - CNT_W     3  hold-counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
// - clk        in   1  single clock, all state on rising edge
// - rst_n      in   1  synchronous reset, active-low
// - req        in   4  request per source; bit0=a, bit1=b, bit2=c, bit3=d
// - out_ready  in   1  downstream accepts the current beat
// - gnt        out  4  one-hot registered grant, 0 when idle
// - s1         out  1  mux select, registered = owner index bit0
// - s2         out  1  mux select, registered = owner index bit1
// - out_valid  out  1  beat on mux output valid = GRANT & req[owner]
// - beat_last  out  1  out_valid & hold_cnt==MAX_HOLD-1 (final beat of this grant)
// BEHAVIOUR
// - Reset (rst_n=0 at edge, any state): state=IDLE, gnt=0, s1=s2=0, hold_cnt=0, rr_ptr=3.
//   out_valid=beat_last=0 from the following cycle. Reset mid-burst drops the burst, no flush.
// - FSM, two states.
//   - IDLE -> GRANT when |req at edge: owner=first set bit scanning rr_ptr+1 upward mod 4.
//   - GRANT: xfer = out_valid & out_ready; each xfer increments hold_cnt.
//   - Release at edge when ~req[owner] (no xfer that cycle), or xfer with hold_cnt==MAX_HOLD-1.
//   - On release: rr_ptr<=owner, hold_cnt<=0, re-pick in same edge from owner+1 mod 4.
//   - Owner is last in scan order, so a lone requester is re-granted with a fresh count.
//   - No candidate -> IDLE, gnt=0; s1/s2 keep their last value.
// - Latency: req rising in IDLE at cycle N -> gnt/s1/s2/out_valid high in N+1.
// - Zero bubble between consecutive grants.
// - s1/s2/gnt change only at grant edges, never while a grant is held; mux path stays stable.
// - out_ready with out_valid=0 has no effect. req on non-owners while GRANT only affects next pick.
// - Owner dropping req mid-grant: out_valid falls combinationally; release at next edge.
// - Index->select map: 0:(s2,s1)=00, 1:01, 2:10, 3:11.
// CONFIGURATION
// - Macro MUX4_ARB_LOCK_EN.
// - Defined: extra input port lock (1 bit).
//   - While lock=1 in GRANT, hold_cnt saturates at MAX_HOLD-1 and hold expiry is ignored.
//   - Release only on ~req[owner]. beat_last forced 0 while lock=1.
// - Undefined: no lock port; behaviour exactly as above.
// STRUCTURE
// - Package mux4_arb_pkg:
//   - NUM_REQ=4, IDX_W=2
//   - state encoding: IDLE=1'b0, GRANT=1'b1
//   - function idx2sel(idx) -> {s2,s1}
//   - function idx2onehot(idx)
// - Sub-module rr_pick4: combinational; in req[3:0], ptr[1:0]; out idx[1:0], found.
//   - Scans ptr+1..ptr mod 4.
//   - Instantiated once, shared by the IDLE and release picks.
// TESTING
// - Reset: rst_n=0 with req=4'hF -> gnt=0, s1=s2=0, out_valid=0; first grant after release is gnt=0001.
// - Single source: req=0100, out_ready=1, MAX_HOLD=4.
//   - gnt=0100, s2s1=10; beat_last on beat 4; re-granted next cycle, no gap.
// - Rotation: req=1111, out_ready=1.
//   - Grants 0001,0010,0100,1000,0001, each 4 beats; s2s1 = 00,01,10,11 in turn.
// - Backpressure: req=0011, out_ready=0 for 10 cycles.
//   - gnt stays 0001, hold_cnt stays 0; after ready=1, 4 beats then gnt=0010.
// - Early drop: owner b drops req after 2 beats with req[d]=1 -> next edge gnt=1000, s2s1=11.
// - Mid-burst reset: rst_n=0 one cycle during beat 3 -> IDLE state, gnt=0, rr_ptr=3.
// - MUX4_ARB_LOCK_EN with lock=1, req=1001: owner a holds >10 beats; lock=0 -> release after the next beat.

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// rtl/mux4_arb_pkg.sv - shared types and helpers for the 4-way round-robin mux arbiter
package mux4_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // {s2,s1}: s2 selects the pair, s1 selects within the pair
   function automatic logic [1:0] idx2sel(input logic [IDX_W-1:0] idx);
      return {idx[1], idx[0]};
   endfunction

   function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// rtl/mux4_rr_arbiter_rr_pick4.sv - combinational round-robin picker, scans ptr+1 .. ptr mod 4
module rr_pick4
   import mux4_arb_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [1:0] idx,
   output logic       found
);

   logic [1:0] cand;

   // Walk from the farthest offset (ptr itself) to the nearest so the nearest wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = ptr + IDX_W'(i);
         if (req[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin owner of the 4:1 mux selects with valid/ready output
// Optional MUX4_ARB_LOCK_EN adds a lock input that suspends hold-count expiry.
module mux4_rr_arbiter
   import mux4_arb_pkg::*;
#(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       out_ready,
`ifdef MUX4_ARB_LOCK_EN
   input  logic       lock,
`endif
   output logic [3:0] gnt,
   output logic       s1,
   output logic       s2,
   output logic       out_valid,
   output logic       beat_last
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state, state_nxt;
   logic [1:0]       owner, owner_nxt;
   logic [1:0]       rr_ptr, rr_ptr_nxt;
   logic [CNT_W-1:0] hold_cnt, hold_nxt;
   logic [3:0]       gnt_nxt;
   logic             s1_nxt, s2_nxt;

   logic             lock_act;
   logic             at_last;
   logic             xfer;
   logic             rel;
   logic [1:0]       pick_ptr;
   logic [1:0]       pick_idx;
   logic             pick_found;

`ifdef MUX4_ARB_LOCK_EN
   assign lock_act = lock;
`else
   assign lock_act = 1'b0;
`endif

   assign out_valid = (state == GRANT) & req[owner];
   assign at_last   = (hold_cnt == LAST);
   assign beat_last = out_valid & at_last & ~lock_act;
   assign xfer      = out_valid & out_ready;
   assign rel       = (state == GRANT) & (~req[owner] | (xfer & at_last & ~lock_act));

   // On release the scan starts after the current owner, making it last in line.
   assign pick_ptr  = (state == GRANT) ? owner : rr_ptr;

   rr_pick4 u_pick (
      .req   (req),
      .ptr   (pick_ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      rr_ptr_nxt = rr_ptr;
      hold_nxt   = hold_cnt;
      gnt_nxt    = gnt;
      s1_nxt     = s1;
      s2_nxt     = s2;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_nxt        = GRANT;
               owner_nxt        = pick_idx;
               gnt_nxt          = idx2onehot(pick_idx);
               {s2_nxt, s1_nxt} = idx2sel(pick_idx);
               hold_nxt         = '0;
            end
         end
         GRANT: begin
            if (rel) begin
               rr_ptr_nxt = owner;
               hold_nxt   = '0;
               if (pick_found) begin
                  owner_nxt        = pick_idx;
                  gnt_nxt          = idx2onehot(pick_idx);
                  {s2_nxt, s1_nxt} = idx2sel(pick_idx);
               end else begin
                  state_nxt = IDLE;
                  gnt_nxt   = '0;
               end
            end else if (xfer && !at_last) begin
               hold_nxt = hold_cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= '0;
         rr_ptr   <= 2'd3;
         hold_cnt <= '0;
         gnt      <= '0;
         s1       <= 1'b0;
         s2       <= 1'b0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         rr_ptr   <= rr_ptr_nxt;
         hold_cnt <= hold_nxt;
         gnt      <= gnt_nxt;
         s1       <= s1_nxt;
         s2       <= s2_nxt;
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed self-checking bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;
   import mux4_arb_pkg::*;

   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic       out_ready;
   logic       lock;
   logic [3:0] gnt;
   logic       s1, s2, out_valid, beat_last;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .out_ready (out_ready),
`ifdef MUX4_ARB_LOCK_EN
      .lock      (lock),
`endif
      .gnt       (gnt),
      .s1        (s1),
      .s2        (s2),
      .out_valid (out_valid),
      .beat_last (beat_last)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   // One full grant: MAX_HOLD beats with ready held high, then step past the release edge.
   task automatic check_grant(input string tag, input logic [3:0] eg, input logic [1:0] esel);
      for (int b = 0; b < MAX_HOLD; b++) begin
         chk({tag, "_gnt"}, 8'(gnt), 8'(eg));
         chk({tag, "_sel"}, 8'({s2, s1}), 8'(esel));
         chk({tag, "_valid"}, 8'(out_valid), 8'd1);
         chk({tag, "_last"}, 8'(beat_last), (b == MAX_HOLD - 1) ? 8'd1 : 8'd0);
         step();
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      req       = 4'hF;
      out_ready = 1'b1;
      lock      = 1'b0;

      // reset with all requesters active
      step();
      chk("rst_gnt", 8'(gnt), 8'h0);
      chk("rst_sel", 8'({s2, s1}), 8'h0);
      chk("rst_valid", 8'(out_valid), 8'h0);
      rst_n = 1'b1;
      step();

      // rotation
      check_grant("rot0", 4'b0001, 2'b00);
      check_grant("rot1", 4'b0010, 2'b01);
      check_grant("rot2", 4'b0100, 2'b10);
      check_grant("rot3", 4'b1000, 2'b11);
      check_grant("rot4", 4'b0001, 2'b00);

      // single source re-granted with no gap
      do_reset();
      req = 4'b0100;
      step();
      check_grant("single0", 4'b0100, 2'b10);
      check_grant("single1", 4'b0100, 2'b10);

      // backpressure
      do_reset();
      req       = 4'b0011;
      out_ready = 1'b0;
      step();
      for (int i = 0; i < 10; i++) begin
         chk("bp_gnt", 8'(gnt), 8'h1);
         chk("bp_valid", 8'(out_valid), 8'h1);
         chk("bp_hold", 8'(dut.hold_cnt), 8'h0);
         step();
      end
      out_ready = 1'b1;
      #1;
      check_grant("bp_run", 4'b0001, 2'b00);
      chk("bp_next", 8'(gnt), 8'h2);

      // early drop by owner b, d waiting
      do_reset();
      req = 4'b1010;
      step();
      chk("drop_gnt_b", 8'(gnt), 8'h2);
      step();
      step();
      req = 4'b1000;
      #1;
      chk("drop_valid", 8'(out_valid), 8'h0);
      step();
      chk("drop_gnt_d", 8'(gnt), 8'h8);
      chk("drop_sel", 8'({s2, s1}), 8'h3);

      // no requesters: back to idle, selects hold
      req = 4'b0000;
      step();
      chk("idle_gnt", 8'(gnt), 8'h0);
      chk("idle_sel", 8'({s2, s1}), 8'h3);
      chk("idle_valid", 8'(out_valid), 8'h0);

      // mid-burst reset during beat 3
      do_reset();
      req = 4'hF;
      step();
      step();
      step();
      chk("mb_hold", 8'(dut.hold_cnt), 8'h2);
      rst_n = 1'b0;
      step();
      chk("mb_gnt", 8'(gnt), 8'h0);
      chk("mb_sel", 8'({s2, s1}), 8'h0);
      chk("mb_valid", 8'(out_valid), 8'h0);
      chk("mb_state", 8'(dut.state), 8'(IDLE));
      chk("mb_ptr", 8'(dut.rr_ptr), 8'h3);
      rst_n = 1'b1;
      step();
      chk("mb_regrant", 8'(gnt), 8'h1);

`ifdef MUX4_ARB_LOCK_EN
      do_reset();
      req  = 4'b1001;
      lock = 1'b1;
      step();
      for (int i = 0; i < 12; i++) begin
         chk("lock_gnt", 8'(gnt), 8'h1);
         chk("lock_last", 8'(beat_last), 8'h0);
         step();
      end
      lock = 1'b0;
      #1;
      chk("unlock_last", 8'(beat_last), 8'h1);
      step();
      chk("unlock_gnt", 8'(gnt), 8'h8);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
